// File: rtl/compressor_12_2_accum_ctrl.sv
// compressor_12_2_accum_ctrl
//   Streams 12-operand beats through a 12:2 carry-save compressor and folds
//   each reduced beat into a signed, silently wrapping accumulator over a
//   programmable number of beats. It owns the start/length handshake, beat
//   and result valid/ready flow control, and the final carry-propagate add.
//
//   Build option: define COMPRESSOR_12_2_ACCUM_PIPE_EN to insert a register
//   stage between the compressor and the carry-propagate adder. That adds a
//   DRAIN state and one cycle of latency; the result value is unchanged.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   start_i, len_i           job start and beat count (sampled in IDLE only)
//   abort_i                  synchronous job cancel, any state
//   busy_o                   high whenever the controller is not IDLE
//   in_valid_i, in_ready_o   beat handshake
//   in_data_i                twelve signed IN_SIZE-bit operands
//   out_valid_o, out_ready_i result handshake
//   out_data_o               signed ACC_WIDTH-bit accumulated result

// 12:2 compressor: sign-extends twelve operands to IN_SIZE+6 bits and
// reduces them with a chain of 3:2 carry-save adders. sum + carry equals
// the operand total modulo 2^(IN_SIZE+6).
module compressor_12_2 #(
  parameter int IN_SIZE = 18
) (
  input  logic [IN_SIZE-1:0] op [0:11],
  output logic [IN_SIZE+5:0] sum,
  output logic [IN_SIZE+5:0] carry
);
  localparam int W = IN_SIZE + 6;

  logic [W-1:0] ext [0:11];
  logic [W-1:0] s   [0:9];
  logic [W-1:0] c   [0:9];
  logic [W-1:0] maj [0:9];

  for (genvar gi = 0; gi < 12; gi++) begin : g_ext
    assign ext[gi] = W'($signed(op[gi]));
  end

  assign s[0]   = ext[0] ^ ext[1] ^ ext[2];
  assign maj[0] = (ext[0] & ext[1]) | (ext[0] & ext[2]) | (ext[1] & ext[2]);
  assign c[0]   = {maj[0][W-2:0], 1'b0};

  // Each stage folds the next operand into the running sum/carry pair.
  for (genvar gi = 1; gi < 10; gi++) begin : g_csa
    assign s[gi]   = s[gi-1] ^ c[gi-1] ^ ext[gi+2];
    assign maj[gi] = (s[gi-1] & c[gi-1]) | (s[gi-1] & ext[gi+2]) |
                     (c[gi-1] & ext[gi+2]);
    assign c[gi]   = {maj[gi][W-2:0], 1'b0};
  end

  assign sum   = s[9];
  assign carry = c[9];
endmodule

module compressor_12_2_accum_ctrl #(
  parameter int IN_SIZE   = 18,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IN_SIZE-1:0]   in_data_i [0:11],
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_WIDTH-1:0] out_data_o
);
  localparam int RED_W = IN_SIZE + 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
`ifdef COMPRESSOR_12_2_ACCUM_PIPE_EN
    , DRAIN = 2'd3
`endif
  } state_t;

  state_t               state_reg, state_next;
  logic                 busy_reg, in_ready_reg, out_valid_reg;
  logic [ACC_WIDTH-1:0] acc_reg;
  logic [LEN_WIDTH-1:0] len_reg, beat_cnt_reg;

  logic [RED_W-1:0]        comp_sum, comp_carry;
  logic [RED_W-1:0]        add_sum, add_carry;
  logic                    add_en;
  logic signed [RED_W-1:0] reduced;
  logic [ACC_WIDTH-1:0]    beat_ext, acc_sum;
  logic                    beat_fire, last_beat;

  compressor_12_2 #(.IN_SIZE(IN_SIZE)) u_comp (
    .op    (in_data_i),
    .sum   (comp_sum),
    .carry (comp_carry)
  );

  assign beat_fire = in_valid_i && in_ready_reg;
  assign last_beat = beat_fire && (beat_cnt_reg == len_reg - LEN_WIDTH'(1));

`ifdef COMPRESSOR_12_2_ACCUM_PIPE_EN
  logic [RED_W-1:0] pipe_sum_reg, pipe_carry_reg;
  logic             pipe_valid_reg;

  // The adder consumes the beat captured one cycle earlier.
  assign add_sum   = pipe_sum_reg;
  assign add_carry = pipe_carry_reg;
  assign add_en    = pipe_valid_reg;
`else
  assign add_sum   = comp_sum;
  assign add_carry = comp_carry;
  assign add_en    = beat_fire;
`endif

  // Carry-propagate add wraps at RED_W bits, then sign-extends.
  assign reduced  = add_sum + add_carry;
  assign beat_ext = ACC_WIDTH'(reduced);
  assign acc_sum  = acc_reg + beat_ext;

  always_comb begin
    state_next = state_reg;
    if (abort_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:  if (start_i) state_next = (len_i == '0) ? DONE : ACCUM;
`ifdef COMPRESSOR_12_2_ACCUM_PIPE_EN
        ACCUM: if (last_beat) state_next = DRAIN;
        DRAIN: state_next = DONE;
`else
        ACCUM: if (last_beat) state_next = DONE;
`endif
        DONE:  if (out_ready_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // Abort takes the same path as reset: everything returns to idle values.
    if (!rst_ni || abort_i) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      acc_reg        <= '0;
      len_reg        <= '0;
      beat_cnt_reg   <= '0;
`ifdef COMPRESSOR_12_2_ACCUM_PIPE_EN
      pipe_sum_reg   <= '0;
      pipe_carry_reg <= '0;
      pipe_valid_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      busy_reg      <= (state_next != IDLE);
      in_ready_reg  <= (state_next == ACCUM);
      out_valid_reg <= (state_next == DONE);

      if (add_en) acc_reg <= acc_sum;
      if (beat_fire) beat_cnt_reg <= beat_cnt_reg + LEN_WIDTH'(1);

`ifdef COMPRESSOR_12_2_ACCUM_PIPE_EN
      pipe_valid_reg <= beat_fire;
      if (beat_fire) begin
        pipe_sum_reg   <= comp_sum;
        pipe_carry_reg <= comp_carry;
      end
`endif

      if (state_reg == IDLE && start_i) begin
        len_reg      <= len_i;
        acc_reg      <= '0;
        beat_cnt_reg <= '0;
      end
    end
  end

  assign busy_o      = busy_reg;
  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = out_valid_reg;
  assign out_data_o  = acc_reg;
endmodule

// File: tb/tb_compressor_12_2_accum_ctrl.sv
module tb_compressor_12_2_accum_ctrl;
`ifdef COMPRESSOR_12_2_ACCUM_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] in_data [0:11];
  logic        busy, in_ready, out_valid;
  logic        busy24, in_ready24, out_valid24;
  logic [31:0] out_data;
  logic [23:0] out_data24;

  logic [17:0] beat_ops [0:11];
  logic [31:0] sb_q [$];
  logic [23:0] sb24_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  compressor_12_2_accum_ctrl #(.IN_SIZE(18), .ACC_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .abort_i(abort),
    .busy_o(busy), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data));

  compressor_12_2_accum_ctrl #(.IN_SIZE(18), .ACC_WIDTH(24), .LEN_WIDTH(8)) dut24 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .abort_i(abort),
    .busy_o(busy24), .in_valid_i(in_valid), .in_ready_o(in_ready24), .in_data_i(in_data),
    .out_valid_o(out_valid24), .out_ready_i(out_ready), .out_data_o(out_data24));

  typedef struct {
    int          len;
    int          op;
    int          bubbles;
    logic [31:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  function automatic logic [31:0] beat_value();
    int s = 0;
    for (int i = 0; i < 12; i++) s += int'($signed(beat_ops[i]));
    return 32'(s);
  endfunction

  task automatic set_ops(input int v);
    for (int i = 0; i < 12; i++) beat_ops[i] = 18'(v);
  endtask

  task automatic start_job(input string name, input int n);
    start = 1'b1;
    len   = 8'(n);
    tick();
    start = 1'b0;
    check({name, "_busy"}, busy, 1);
    if (n != 0) check({name, "_rdy"}, in_ready, 1);
  endtask

  task automatic send_beat();
    in_valid = 1'b1;
    in_data  = beat_ops;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int lat_exp);
    int cyc = 1;
    while (!out_valid && cyc < 16) begin
      tick();
      cyc++;
    end
    check({name, "_lat"}, cyc, lat_exp);
  endtask

  task automatic consume(input string name);
    logic [31:0] e;
    logic [23:0] e24;
    if (sb_q.size() == 0 || sb24_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_sb: actual=empty required=entry", name);
      return;
    end
    e   = sb_q.pop_front();
    e24 = sb24_q.pop_front();
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, out_data, e);
    check({name, "_d24"}, out_data24, e24);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_idle"}, {busy, out_valid, in_ready}, 0);
  endtask

  vec_t vecs [5];

  initial begin
    logic [31:0] acc;
    int nb, bub;

    vecs[0] = '{len: 1,  op: 1,       bubbles: 0, exp: 32'd12};
    vecs[1] = '{len: 3,  op: -1,      bubbles: 1, exp: 32'hFFFF_FFDC};
    vecs[2] = '{len: 11, op: 131071,  bubbles: 0, exp: 32'd17301372};
    vecs[3] = '{len: 2,  op: -131072, bubbles: 0, exp: 32'hFFD0_0000};
    vecs[4] = '{len: 4,  op: 5,       bubbles: 2, exp: 32'd240};

    set_ops(0);
    in_data = beat_ops;

    // Reset values
    tick();
    tick();
    check("rst_outs", {busy, in_ready, out_valid}, 0);
    check("rst_data", out_data, 0);
    check("rst_d24", out_data24, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven jobs
    for (int v = 0; v < 5; v++) begin
      sb_q.push_back(vecs[v].exp);
      sb24_q.push_back(vecs[v].exp[23:0]);
      set_ops(vecs[v].op);
      start_job($sformatf("vec%0d", v), vecs[v].len);
      for (int b = 0; b < vecs[v].len; b++) begin
        send_beat();
        if (b < vecs[v].len - 1)
          for (int k = 0; k < vecs[v].bubbles; k++) tick();
      end
      wait_valid($sformatf("vec%0d", v), LAT);
      consume($sformatf("vec%0d", v));
    end

    // Result backpressure with start held high in DONE
    set_ops(3);
    sb_q.push_back(32'd36);
    sb24_q.push_back(24'd36);
    start_job("bp", 1);
    send_beat();
    wait_valid("bp", LAT);
    start = 1'b1;
    len   = 8'd1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold%0d", k), {out_valid, in_ready, busy, out_data}, {3'b101, 32'd36});
    end
    start = 1'b0;
    consume("bp");
    set_ops(1);
    sb_q.push_back(32'd12);
    sb24_q.push_back(24'd12);
    start_job("bp_next", 1);
    send_beat();
    wait_valid("bp_next", LAT);
    consume("bp_next");

    // Abort on beat 2 of a len=4 job, together with a valid beat
    set_ops(9);
    start_job("abort", 4);
    send_beat();
    in_valid = 1'b1;
    abort    = 1'b1;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    check("abort_state", {busy, in_ready, out_valid}, 0);
    check("abort_acc", out_data, 0);
    tick();
    tick();
    check("abort_novalid", out_valid, 0);
    set_ops(2);
    sb_q.push_back(32'd24);
    sb24_q.push_back(24'd24);
    start_job("post_abort", 1);
    send_beat();
    wait_valid("post_abort", LAT);
    consume("post_abort");

    // Zero-length job goes straight to DONE with a zero result
    sb_q.push_back(32'd0);
    sb24_q.push_back(24'd0);
    start_job("len0", 0);
    wait_valid("len0", 1);
    consume("len0");

    // Reset asserted mid-ACCUM
    set_ops(7);
    start_job("rst_mid", 3);
    send_beat();
    rst_n = 1'b0;
    tick();
    check("rst_mid_outs", {busy, in_ready, out_valid}, 0);
    check("rst_mid_data", out_data, 0);
    rst_n = 1'b1;
    tick();
    check("rst_mid_quiet", out_valid, 0);

    // Random jobs, expected value from an independent sum model
    for (int j = 0; j < 4; j++) begin
      nb  = int'($urandom_range(1, 6));
      acc = '0;
      start_job($sformatf("rnd%0d", j), nb);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 12; i++) beat_ops[i] = 18'($urandom);
        acc += beat_value();
        send_beat();
        bub = int'($urandom_range(0, 2));
        if (b < nb - 1)
          for (int k = 0; k < bub; k++) tick();
      end
      sb_q.push_back(acc);
      sb24_q.push_back(acc[23:0]);
      wait_valid($sformatf("rnd%0d", j), LAT);
      consume($sformatf("rnd%0d", j));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
